qsfp_i2c_lb_sched: RTL and testbench

Schedules the single read port of the I2C chunk-engine result memory between the host QSFP register reader and a periodic poller of the Marble U34 GPIO expander. Every transaction is a two-byte read: byte at address a, then a+1, packed big-endian into 16 bits. Decoded `present_n` and the raw status word come from the periodic U34 poll. The block sits between the GPIO-bus decode and the chunk engine's `lb_addr`/`lb_dout`/`freeze` pins.

---
 rtl/qsfp_i2c_lb_sched_pkg.sv | 25 ++
 rtl/qsfp_i2c_lb_sched_reader.sv | 89 ++++++++
 rtl/qsfp_i2c_lb_sched.sv | 118 +++++++++++
 tb/tb_qsfp_i2c_lb_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsfp_i2c_lb_sched_pkg.sv
// Shared types for the QSFP/U34 result-memory read scheduler.
// State encoding, address widths and transaction owner encoding.
package qsfp_sched_pkg;

    localparam int MEM_AW = 10;
    localparam int LB_AW  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD0  = 2'd1,
        ST_RD1  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_POLL = 1'b1
    } owner_t;

    function automatic logic [LB_AW-1:0] lb_map(input logic [LB_AW-1:0] base,
                                                input logic [MEM_AW-1:0] off);
        return base | {{(LB_AW-MEM_AW){1'b0}}, off};
    endfunction

endpackage

// File: rtl/qsfp_i2c_lb_sched_reader.sv
// Two-byte big-endian read of the result memory: byte at a, then a+1 (mod 1024).
// done pulses in the last RD1 cycle with word = {byte0, lb_dout}; DONE follows.
module lb_byte_pair_reader
    import qsfp_sched_pkg::*;
#(
    parameter int               RAM_LATENCY  = 1,
    parameter logic [LB_AW-1:0] RESULTS_BASE = 12'h800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MEM_AW-1:0] offset,
    output logic [LB_AW-1:0]  lb_addr,
    input  logic [7:0]        lb_dout,
    output logic              busy,
    output logic              done,
    output logic [15:0]       word
);

    localparam int WAIT_W = (RAM_LATENCY > 0) ? $clog2(RAM_LATENCY + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RAM_LATENCY);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [MEM_AW-1:0]   off_q, off_d;
    logic [7:0]          byte0_q, byte0_d;
    logic [LB_AW-1:0]    lb_addr_q, lb_addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            off_q     <= '0;
            byte0_q   <= '0;
            lb_addr_q <= RESULTS_BASE;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            off_q     <= off_d;
            byte0_q   <= byte0_d;
            lb_addr_q <= lb_addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        off_d     = off_q;
        byte0_d   = byte0_q;
        lb_addr_d = lb_addr_q;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    off_d     = offset;
                    lb_addr_d = lb_map(RESULTS_BASE, offset);
                    wait_d    = WAIT_INIT;
                    state_d   = ST_RD0;
                end
            end
            ST_RD0: begin
                if (wait_q == '0) begin
                    byte0_d   = lb_dout;
                    // 10-bit add wraps 3FF -> 000 inside the result window
                    lb_addr_d = lb_map(RESULTS_BASE, off_q + MEM_AW'(1));
                    wait_d    = WAIT_INIT;
                    state_d   = ST_RD1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_RD1: begin
                if (wait_q == '0) begin
                    done    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign lb_addr = lb_addr_q;
    assign busy    = (state_q != ST_IDLE);
    assign word    = {byte0_q, lb_dout};

endmodule

// File: rtl/qsfp_i2c_lb_sched.sv
// Arbitrates the chunk-engine result read port between host reads and a periodic U34 poll.
// Optional QSFP_SCHED_FREEZE_EN holds freeze from grant through DONE; otherwise freeze is 0.
module qsfp_i2c_lb_sched
    import qsfp_sched_pkg::*;
#(
    parameter int                RAM_LATENCY   = 1,
    parameter int                POLL_INTERVAL = 1000000,
    parameter logic [LB_AW-1:0]  RESULTS_BASE  = 12'h800,
    parameter logic [MEM_AW-1:0] U34_OFFSET    = 10'h000,
    parameter int                PRS0_BIT      = 4,
    parameter int                PRS1_BIT      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic [MEM_AW-1:0] host_addr,
    output logic              host_ack,
    output logic [15:0]       host_data,
    output logic [LB_AW-1:0]  lb_addr,
    input  logic [7:0]        lb_dout,
    output logic              freeze,
    output logic [15:0]       status_word,
    output logic              status_valid,
    output logic [1:0]        present_n
);

    localparam int TMR_W = $clog2(POLL_INTERVAL);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_INTERVAL - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             poll_pending_q, poll_pending_d;
    logic             last_host_q, last_host_d;
    owner_t           owner_q, owner_d;
    logic             host_ack_q, host_ack_d;
    logic [15:0]      host_data_q, host_data_d;
    logic [15:0]      status_word_q, status_word_d;
    logic             status_valid_q, status_valid_d;

    logic              rd_busy, rd_done;
    logic [15:0]       rd_word;
    logic              grant, grant_host, grant_poll, expire;
    logic [MEM_AW-1:0] start_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q          <= TMR_RELOAD;
            poll_pending_q <= 1'b0;
            last_host_q    <= 1'b0;
            owner_q        <= OWN_HOST;
            host_ack_q     <= 1'b0;
            host_data_q    <= '0;
            status_word_q  <= 16'hFFFF;
            status_valid_q <= 1'b0;
        end else begin
            tmr_q          <= tmr_d;
            poll_pending_q <= poll_pending_d;
            last_host_q    <= last_host_d;
            owner_q        <= owner_d;
            host_ack_q     <= host_ack_d;
            host_data_q    <= host_data_d;
            status_word_q  <= status_word_d;
            status_valid_q <= status_valid_d;
        end
    end

    always_comb begin
        expire = (tmr_q == '0);
        tmr_d  = expire ? TMR_RELOAD : tmr_q - 1'b1;

        // Under contention the requester not served last goes first
        grant      = ~rd_busy & (host_req | poll_pending_q);
        grant_host = grant & host_req & (~poll_pending_q | ~last_host_q);
        grant_poll = grant & ~grant_host;

        poll_pending_d = expire | (poll_pending_q & ~grant_poll);
        last_host_d    = grant ? grant_host : last_host_q;
        owner_d        = owner_q;
        if (grant) owner_d = grant_host ? OWN_HOST : OWN_POLL;
        start_off = grant_host ? host_addr : U34_OFFSET;

        host_ack_d     = rd_done & (owner_q == OWN_HOST);
        host_data_d    = host_ack_d ? rd_word : host_data_q;
        status_word_d  = status_word_q;
        status_valid_d = status_valid_q;
        if (rd_done && owner_q == OWN_POLL) begin
            status_word_d  = rd_word;
            status_valid_d = 1'b1;
        end
    end

    lb_byte_pair_reader #(
        .RAM_LATENCY  (RAM_LATENCY),
        .RESULTS_BASE (RESULTS_BASE)
    ) u_reader (
        .clk     (clk),
        .rst     (rst),
        .start   (grant),
        .offset  (start_off),
        .lb_addr (lb_addr),
        .lb_dout (lb_dout),
        .busy    (rd_busy),
        .done    (rd_done),
        .word    (rd_word)
    );

`ifdef QSFP_SCHED_FREEZE_EN
    assign freeze = ~rst & (rd_busy | grant);
`else
    assign freeze = 1'b0;
`endif

    assign host_ack     = host_ack_q;
    assign host_data    = host_data_q;
    assign status_word  = status_word_q;
    assign status_valid = status_valid_q;
    assign present_n    = {status_word_q[PRS1_BIT], status_word_q[PRS0_BIT]};

endmodule

// File: tb/tb_qsfp_i2c_lb_sched.sv
// Bench for qsfp_i2c_lb_sched: memory model with one-cycle read latency, directed and random reads.
module tb_qsfp_i2c_lb_sched;

    localparam int PI = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_req = 1'b0;
    logic [9:0]  host_addr = '0;
    logic        host_ack;
    logic [15:0] host_data;
    logic [11:0] lb_addr;
    logic [7:0]  lb_dout = '0;
    logic        freeze;
    logic [15:0] status_word;
    logic        status_valid;
    logic [1:0]  present_n;

    qsfp_i2c_lb_sched #(
        .RAM_LATENCY   (1),
        .POLL_INTERVAL (PI),
        .RESULTS_BASE  (12'h800),
        .U34_OFFSET    (10'h000),
        .PRS0_BIT      (4),
        .PRS1_BIT      (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host_req     (host_req),
        .host_addr    (host_addr),
        .host_ack     (host_ack),
        .host_data    (host_data),
        .lb_addr      (lb_addr),
        .lb_dout      (lb_dout),
        .freeze       (freeze),
        .status_word  (status_word),
        .status_valid (status_valid),
        .present_n    (present_n)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [4096];
    always @(posedge clk) lb_dout <= mem[lb_addr];

    // Observed lb_addr change history and freeze-high cycle count
    logic [11:0] addr_log [$];
    logic [11:0] prev_lb = 12'h800;
    int          frz_cnt = 0;
    always @(negedge clk) begin
        if (lb_addr !== prev_lb) addr_log.push_back(lb_addr);
        prev_lb <= lb_addr;
        if (freeze === 1'b1) frz_cnt <= frz_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (host_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Request becomes visible this cycle (t); ack must land exactly at t+5
    task automatic host_read_exact(input string tag, input logic [9:0] a, input logic [15:0] exp_v);
        host_addr = a;
        host_req  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k < 5) chk({tag, "_ack_early"}, host_ack, 1'b0);
        end
        chk({tag, "_ack_t5"}, host_ack, 1'b1);
        chk({tag, "_data"}, host_data, exp_v);
        host_req = 1'b0;
        step();
        chk({tag, "_ack_pulse"}, host_ack, 1'b0);
    endtask

    logic [11:0] idx0, idx1;
    logic [15:0] exp_d, exp_sw;
    logic [9:0]  a;
    bit          ok, found;
    int          mark, fmark, pcount;
    bit          owners [$];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h810] = 8'hAB;
        mem[12'h811] = 8'hCD;
        mem[12'h800] = 8'hEF;
        mem[12'h801] = 8'hEF;

        // Reset values
        step();
        step();
        chk("rst_ack", host_ack, 1'b0);
        chk("rst_data", host_data, 16'h0000);
        chk("rst_lb_addr", lb_addr, 12'h800);
        chk("rst_freeze", freeze, 1'b0);
        chk("rst_status", status_word, 16'hFFFF);
        chk("rst_valid", status_valid, 1'b0);
        chk("rst_present", present_n, 2'b11);

        // Host request contends with the first poll: host first, poll next
        rst = 1'b0;
        mark  = addr_log.size();
        fmark = frz_cnt;
        repeat (PI) step();
        host_read_exact("host010", 10'h010, 16'hABCD);
        chk("valid_before_poll", status_valid, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step();
            if (status_valid === 1'b1) ok = 1'b1;
        end
        chk("poll_done", ok, 1'b1);
        chk("poll_status", status_word, 16'hEFEF);
        chk("poll_present", present_n, 2'b00);
        chk("order_0", addr_log[mark], 12'h810);
        chk("order_1", addr_log[mark+1], 12'h811);
        chk("order_2", addr_log[mark+2], 12'h800);
        chk("order_3", addr_log[mark+3], 12'h801);
        step();
        step();
`ifdef QSFP_SCHED_FREEZE_EN
        chk("freeze_two_txn", frz_cnt - fmark, 12);
`endif

        // Wrap from 3FF to 000
        mem[12'hBFF] = 8'h12;
        mem[12'h800] = 8'h34;
        mark = addr_log.size();
        host_addr = 10'h3FF;
        host_req  = 1'b1;
        wait_ack(ok);
        chk("wrap_ack", ok, 1'b1);
        chk("wrap_data", host_data, 16'h1234);
        host_req = 1'b0;
        found = 1'b0;
        for (int i = mark; i + 1 < addr_log.size(); i++) begin
            if (!found && addr_log[i] == 12'hBFF) begin
                chk("wrap_next_addr", addr_log[i+1], 12'h800);
                found = 1'b1;
            end
        end
        chk("wrap_seen", found, 1'b1);

        // Random host reads; U34 bytes are left alone
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 4)) step();
            a    = 10'($urandom_range(0, 1023));
            idx0 = 12'h800 | {2'b00, a};
            idx1 = 12'h800 | {2'b00, 10'(a + 10'd1)};
            if (idx0 > 12'h801) mem[idx0] = 8'($urandom);
            if (idx1 > 12'h801) mem[idx1] = 8'($urandom);
            exp_d     = {mem[idx0], mem[idx1]};
            host_addr = a;
            host_req  = 1'b1;
            wait_ack(ok);
            chk("rand_ack", ok, 1'b1);
            chk("rand_data", host_data, exp_d);
            host_req = 1'b0;
            step();
            chk("rand_ack_pulse", host_ack, 1'b0);
            chk("rand_data_held", host_data, exp_d);
        end

        // Status follows the current U34 bytes after further polls
        repeat (3 * PI) step();
        exp_sw = {mem[12'h800], mem[12'h801]};
        chk("status_later", status_word, exp_sw);
        chk("present_later", present_n, {exp_sw[12], exp_sw[4]});
        chk("valid_later", status_valid, 1'b1);

        // Reset in the middle of RD1
        a = 10'($urandom_range(16, 1000));
        idx1 = 12'h800 | {2'b00, 10'(a + 10'd1)};
        host_addr = a;
        host_req  = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            step();
            if (lb_addr === idx1) ok = 1'b1;
        end
        chk("reach_rd1", ok, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_freeze", freeze, 1'b0);
        chk("midrst_ack", host_ack, 1'b0);
        chk("midrst_present", present_n, 2'b11);
        chk("midrst_valid", status_valid, 1'b0);
        chk("midrst_status", status_word, 16'hFFFF);
        chk("midrst_lb_addr", lb_addr, 12'h800);
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (host_ack === 1'b1) found = 1'b1;
        end
        chk("midrst_no_ack", found, 1'b0);
        host_req = 1'b0;
        step();
        rst = 1'b0;
        a = 10'($urandom_range(16, 1000));
        idx0 = 12'h800 | {2'b00, a};
        idx1 = 12'h800 | {2'b00, 10'(a + 10'd1)};
        fmark = frz_cnt;
        host_read_exact("after_rst", a, {mem[idx0], mem[idx1]});
        step();
`ifdef QSFP_SCHED_FREEZE_EN
        chk("freeze_one_txn", frz_cnt - fmark, 6);
`endif

        // Host held continuously: poll is never starved and never served twice in a row
        do_reset();
        mark = addr_log.size();
        repeat (PI) step();
        host_addr = 10'h100;
        host_req  = 1'b1;
        repeat (150) step();
        host_req = 1'b0;
        repeat (12) step();
        for (int i = mark; i < addr_log.size(); i++) begin
            if (addr_log[i] == 12'h900) owners.push_back(1'b1);
            if (addr_log[i] == 12'h800) owners.push_back(1'b0);
        end
        chk("held_first_host", owners.size() > 0 ? owners[0] : 1'bx, 1'b1);
        chk("held_second_poll", owners.size() > 1 ? owners[1] : 1'bx, 1'b0);
        pcount = 0;
        for (int i = 0; i < owners.size(); i++) begin
            if (!owners[i]) begin
                pcount++;
                if (i + 1 < owners.size()) chk("held_host_after_poll", owners[i+1], 1'b1);
            end
        end
        chk("held_poll_count_ge3", pcount >= 3, 1'b1);

`ifndef QSFP_SCHED_FREEZE_EN
        chk("freeze_never_high", frz_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
